jtframe_bank_slots: RTL



---
 rtl/jtframe_bank_pkg.sv | 20 ++
 rtl/jtframe_slot_cache.sv | 47 ++++
 rtl/jtframe_bank_slots.sv | 126 ++++++++++++
 3 files changed

// File: rtl/jtframe_bank_pkg.sv
// Shared types for the multi-slot SDRAM bank client.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package jtframe_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } st_t;

   // Slot-index width; never below one bit so a single-slot build still has a legal index
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/jtframe_slot_cache.sv
// One-word tagged cache for a single ROM reader slot.
// Latency: ok/dout registered; hit gives ok one cycle later, a fill gives ok the cycle after ba_rdy.
// Backpressure: none; the top only fills a slot when its transaction completes.
module jtframe_slot_cache #(
   parameter int AW = 22
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inv,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          load,
   input  logic [AW-1:0] load_addr,
   input  logic [15:0]   load_data,
   output logic          hit,
   output logic          ok,
   output logic [15:0]   dout
);

   logic [AW-1:0] tag;
   logic          valid;
   logic          fill;

   assign hit  = cs & valid & (tag == addr);
   // A fill that coincides with an invalidate is discarded
   assign fill = load & ~inv;

   // Tag/valid/data update; ok also covers the fill cycle so data is usable right after ba_rdy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag   <= '0;
         valid <= 1'b0;
         dout  <= '0;
         ok    <= 1'b0;
      end else begin
         ok <= ~inv & (hit | (fill & cs & (load_addr == addr)));
         if (inv) begin
            valid <= 1'b0;
         end else if (fill) begin
            valid <= 1'b1;
            tag   <= load_addr;
            dout  <= load_data;
         end
      end
   end

endmodule

// File: rtl/jtframe_bank_slots.sv
// Shares one SDRAM bank port among SLOTS cached ROM readers (fixed or round-robin arbitration).
// Latency: hit -> slot_ok in 1 cycle; miss -> ba_rd next cycle, slot_ok the cycle after ba_rdy.
// Backpressure: one outstanding request; ba_rd held until ba_ack, no new grant while inv is high.
module jtframe_bank_slots
   import jtframe_bank_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int AW    = 22,
   parameter int RR    = 1
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inv,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS-1:0]    slot_ok,
   output logic [SLOTS*16-1:0] slot_dout,
   output logic [AW-1:0]       ba_addr,
   output logic                ba_rd,
   input  logic                ba_ack,
   input  logic                ba_dst,
   input  logic                ba_dok,
   input  logic                ba_rdy,
   input  logic [15:0]         sdram_dout
);

   localparam int IW = clog2(SLOTS);

   st_t            st, st_nx;
   logic [IW-1:0]  gnt, gnt_nx;
   logic [IW-1:0]  ptr, ptr_nx;
   logic [AW-1:0]  addr_nx;
   logic [SLOTS-1:0] hit, miss, inflight, load;
   logic           sel_vld;
   logic [IW-1:0]  sel;

   // Decoded from the state register so an async reset drops the request at once
   assign ba_rd = (st == ST_REQ);
   assign miss  = slot_cs & ~hit & ~inflight;

   genvar i;
   generate
      for (i = 0; i < SLOTS; i++) begin : g_slot
         jtframe_slot_cache #(.AW(AW)) u_cache (
            .clk       (clk),
            .rst_n     (rst_n),
            .inv       (inv),
            .cs        (slot_cs[i]),
            .addr      (slot_addr[i*AW +: AW]),
            .load      (load[i]),
            .load_addr (ba_addr),
            .load_data (sdram_dout),
            .hit       (hit[i]),
            .ok        (slot_ok[i]),
            .dout      (slot_dout[i*16 +: 16])
         );
      end
   endgenerate

   // Slot ownership of the current transaction and the fill strobe on ba_rdy
   always_comb begin
      inflight = '0;
      load     = '0;
      if (st != ST_IDLE) inflight[gnt] = 1'b1;
      if (st == ST_WAIT && ba_rdy) load[gnt] = 1'b1;
   end

   // Arbiter: first missing slot at or after the start point, wrapping; fixed mode starts at 0
   always_comb begin
      int idx;
      idx     = 0;
      sel_vld = 1'b0;
      sel     = '0;
      for (int k = 0; k < SLOTS; k++) begin
         idx = k + ((RR != 0) ? int'(ptr) : 0);
         if (idx >= SLOTS) idx = idx - SLOTS;
         if (!sel_vld && miss[idx]) begin
            sel_vld = 1'b1;
            sel     = IW'(idx);
         end
      end
   end

   // Next-state logic: IDLE grants, REQ waits for ack, WAIT waits for data
   always_comb begin
      st_nx   = st;
      gnt_nx  = gnt;
      ptr_nx  = ptr;
      addr_nx = ba_addr;
      case (st)
         ST_IDLE: begin
            if (sel_vld && !inv) begin
               st_nx   = ST_REQ;
               gnt_nx  = sel;
               addr_nx = slot_addr[int'(sel)*AW +: AW];
               if (RR != 0) ptr_nx = (int'(sel) == SLOTS-1) ? '0 : sel + 1'b1;
            end
         end
         ST_REQ:  if (ba_ack) st_nx = ST_WAIT;
         ST_WAIT: if (ba_rdy) st_nx = ST_IDLE;
         default: st_nx = ST_IDLE;
      endcase
   end

   // State, grant, pointer and issued address registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_IDLE;
         gnt     <= '0;
         ptr     <= '0;
         ba_addr <= '0;
      end else begin
         st      <= st_nx;
         gnt     <= gnt_nx;
         ptr     <= ptr_nx;
         ba_addr <= addr_nx;
      end
   end

   // Controller handshake must follow the FSM phase
   a_rdy_in_wait: assert property (@(posedge clk) disable iff (!rst_n) ba_rdy |-> st == ST_WAIT);
   a_ack_in_req:  assert property (@(posedge clk) disable iff (!rst_n) ba_ack |-> st == ST_REQ);
   a_dst_in_wait: assert property (@(posedge clk) disable iff (!rst_n) ba_dst |-> st == ST_WAIT);
   a_rdy_dok:     assert property (@(posedge clk) disable iff (!rst_n) ba_rdy |-> ba_dok);

endmodule
